data_memory: RTL and testbench
==============================

// Module: data_memory
//
// PURPOSE
// - 256 x 8 data memory with a multi-cycle access model and a BUSYWAIT stall handshake.
// - Sits downstream of the ALU, which supplies ADDRESS.
// - Sits upstream of the register-file write-back mux, which receives READDATA.
// - BUSYWAIT fans out to the PC and reg_file. Both hold state while it is high.
//
// PARAMETERS
// - ADDR_W   8    address width in bits
// - DATA_W   8    data word width in bits
// - DEPTH    256  number of words (2**ADDR_W)
// - LATENCY  5    cycles from request acceptance to operation commit (>=1)
//
// PORTS
// - CLK        in   1       clock; all state changes on posedge
// - RESET      in   1       synchronous, active-high reset
// - READ       in   1       load request from control unit
// - WRITE      in   1       store request from control unit
// - ADDRESS    in   ADDR_W  word address (ALU result)
// - WRITEDATA  in   DATA_W  store data (register file OUT1)
// - READDATA   out  DATA_W  load result to write-back mux
// - BUSYWAIT   out  1       stall: CPU must freeze PC and register writes
//
// BEHAVIOUR
// - Reset state
//   - RESET=1 at a posedge: state=IDLE, counter=0, latched request cleared, READDATA=0.
//   - Memory array contents are preserved across reset.
//   - BUSYWAIT is forced 0 while RESET=1.
// - FSM: IDLE -> BUSY -> DONE -> IDLE
//   - IDLE: on a posedge with READ|WRITE=1, latch op, ADDRESS and WRITEDATA; counter=LATENCY-1; go to BUSY.
//   - BUSY: decrement counter each posedge.
//     - At the edge where counter==0, commit the op: store writes mem[addr]; load writes READDATA=mem[addr].
//     - Then go to DONE.
//   - DONE: lasts one cycle and returns to IDLE unconditionally.
//     - READ/WRITE are ignored in DONE; they still belong to the completing instruction.
// - BUSYWAIT (combinational)
//   - BUSYWAIT = !RESET && ((IDLE && (READ|WRITE)) || BUSY).
//   - This stalls the CPU in the same cycle the request appears.
//   - BUSYWAIT is 0 in DONE. The CPU advances on that edge, and reg_file captures READDATA on that edge.
// - Latency
//   - Request present in cycle 0; BUSYWAIT is high for cycles 0..LATENCY.
//   - BUSYWAIT is low in cycle LATENCY+1 (DONE).
//   - Total stall is LATENCY+1 cycles.
// - READDATA
//   - Valid from DONE onward.
//   - Held until the next load commits; stores do not change it.
// - Request changes while BUSY: ignored. Only the values latched in IDLE are used.
// - READ and WRITE both high in IDLE: treated as WRITE; READDATA is unchanged.
// - RESET mid-BUSY: abort. No memory write occurs, READDATA=0, IDLE on the next cycle.
// - Back-to-back accesses: a new request is only accepted from IDLE, one cycle after DONE.
// - Address wrap: ADDRESS is taken modulo DEPTH, with no out-of-range error.
//
// STRUCTURE
// - Shared package cpu_pkg holds:
//   - DMEM_LATENCY, DMEM_DEPTH;
//   - state encodings DM_IDLE=2'd0, DM_BUSY=2'd1, DM_DONE=2'd2.
// - One sub-module, dmem_array: a synchronous single-port storage array.
//   - Ports: clk, we, addr, wdata, rdata.
// - The FSM, counter, request latches and BUSYWAIT logic live in data_memory.
//
// TESTING
// - Reset: RESET=1 for 2 cycles with READ=1 -> BUSYWAIT=0 throughout, READDATA=0, state IDLE.
// - Store then load:
//   - WRITE=1, ADDRESS=8'h10, WRITEDATA=8'hA5 -> BUSYWAIT high for 6 cycles, low in cycle 6.
//   - Then READ=1, ADDRESS=8'h10 -> READDATA=8'hA5 in DONE.
// - Request change mid-BUSY:
//   - Start READ at 8'h10.
//   - In cycle 2, switch to ADDRESS=8'h20 with WRITE=1.
//   - Required: load of 8'h10 completes, and mem[8'h20] is unchanged.
// - Reset mid-store:
//   - WRITE 8'h3C to 8'h05; assert RESET in cycle 3.
//   - Required: BUSYWAIT=0 next cycle, and a later read of 8'h05 returns the old value (not 8'h3C).
// - Back-to-back:
//   - Load at 8'hFF, then immediately a store 8'h11 to 8'h00 presented in the cycle after DONE.
//   - Required: second access accepted, total 12 stall cycles, READDATA holds mem[8'hFF].
// - Simultaneous READ=WRITE=1, ADDRESS=8'h40, WRITEDATA=8'h77 -> mem[8'h40]=8'h77, READDATA unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data memory geometry, access latency and FSM state encodings.
package cpu_pkg;

  localparam int DMEM_ADDR_W  = 8;
  localparam int DMEM_DATA_W  = 8;
  localparam int DMEM_DEPTH   = 256;
  localparam int DMEM_LATENCY = 5;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_BUSY = 2'd1,
    DM_DONE = 2'd2
  } dm_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port storage array: synchronous write, combinational read of the addressed word.
module dmem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_memory.sv
// Multi-cycle 256x8 data memory; stalls the CPU through BUSYWAIT until the access commits.
module data_memory
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W,
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = DMEM_LATENCY
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              READ,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] ADDRESS,
  input  logic [DATA_W-1:0] WRITEDATA,
  output logic [DATA_W-1:0] READDATA,
  output logic              BUSYWAIT
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  dm_state_t         state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic              op_write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] readdata_q;
  logic [DATA_W-1:0] arr_rdata;
  logic              req;
  logic              commit;
  logic              arr_we;

  // Handshake: BUSYWAIT rises combinationally with READ|WRITE in IDLE and stays high
  // through BUSY; the CPU holds PC/regs while high and advances on the DONE edge,
  // where READDATA is already valid. Inputs are only sampled in IDLE.
  assign req      = READ | WRITE;
  assign commit   = (state_q == DM_BUSY) && (count_q == '0);
  assign arr_we   = commit && op_write_q && !RESET;
  assign BUSYWAIT = !RESET && (((state_q == DM_IDLE) && req) || (state_q == DM_BUSY));
  assign READDATA = readdata_q;

  dmem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_array (
    .clk  (CLK),
    .we   (arr_we),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(arr_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      DM_IDLE: if (req) state_d = DM_BUSY;
      DM_BUSY: if (count_q == '0) state_d = DM_DONE;
      DM_DONE: state_d = DM_IDLE;
      default: state_d = DM_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= DM_IDLE;
      count_q    <= '0;
      op_write_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        DM_IDLE: begin
          if (req) begin
            // A simultaneous READ and WRITE is treated as a store.
            op_write_q <= WRITE;
            addr_q     <= ADDRESS;
            wdata_q    <= WRITEDATA;
            count_q    <= CNT_INIT;
          end
        end
        DM_BUSY: begin
          if (commit) begin
            if (!op_write_q) readdata_q <= arr_rdata;
          end else begin
            count_q <= count_q - CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: stall length, load/store results, reset and corner cases.
module tb_data_memory;
  import cpu_pkg::*;

  localparam int LAT = DMEM_LATENCY;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  int checks   = 0;
  int failures = 0;

  logic [7:0] model_mem [256];
  logic [7:0] exp_rd;
  logic [7:0] exp_q [$];

  data_memory dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .READ     (READ),
    .WRITE    (WRITE),
    .ADDRESS  (ADDRESS),
    .WRITEDATA(WRITEDATA),
    .READDATA (READDATA),
    .BUSYWAIT (BUSYWAIT)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Counts BUSYWAIT-high cycles (sampled at negedge) until it drops; leaves us in DONE.
  task automatic wait_done(output int stall, output logic timed_out);
    stall     = 0;
    timed_out = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge CLK);
      if (!BUSYWAIT) begin
        timed_out = 1'b0;
        break;
      end
      stall++;
    end
  endtask

  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [7:0] a, input logic [7:0] d, output int stall);
    logic to;
    logic [7:0] e;
    @(posedge CLK); #1;
    READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
    if (wr) model_mem[a] = d;
    else if (rd) exp_rd = model_mem[a];
    exp_q.push_back(exp_rd);
    wait_done(stall, to);
    check({tag, " timeout"}, {31'd0, to}, 32'd0);
    check({tag, " stall"}, stall, LAT + 1);
    check({tag, " state"}, dut.state_q, DM_DONE);
    e = exp_q.pop_front();
    check({tag, " readdata"}, READDATA, e);
    READ = 1'b0; WRITE = 1'b0;
  endtask

  initial begin
    int s, s1, s2;
    logic to;

    RESET = 1'b1; READ = 1'b1; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    exp_rd = 8'h00;

    // reset held 2 cycles with READ asserted
    @(posedge CLK);
    @(negedge CLK);
    check("rst busywait c0", BUSYWAIT, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("rst busywait c1", BUSYWAIT, 0);
    check("rst readdata", READDATA, 8'h00);
    check("rst state", dut.state_q, DM_IDLE);
    @(posedge CLK); #1;
    RESET = 1'b0; READ = 1'b0;

    // store then load
    access("st10", 1'b0, 1'b1, 8'h10, 8'hA5, s);
    access("ld10", 1'b1, 1'b0, 8'h10, 8'h00, s);

    // request change while busy
    access("st20", 1'b0, 1'b1, 8'h20, 8'h5A, s);
    @(posedge CLK); #1;
    READ = 1'b1; WRITE = 1'b0; ADDRESS = 8'h10;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h20; WRITEDATA = 8'hEE;
    wait_done(s, to);
    check("midbusy timeout", {31'd0, to}, 32'd0);
    check("midbusy stall from c2", s, LAT - 1);
    check("midbusy readdata", READDATA, 8'hA5);
    READ = 1'b0; WRITE = 1'b0;
    exp_rd = 8'hA5;
    access("ld20 untouched", 1'b1, 1'b0, 8'h20, 8'h00, s);

    // reset in the middle of a store
    access("st05", 1'b0, 1'b1, 8'h05, 8'hC3, s);
    @(posedge CLK); #1;
    WRITE = 1'b1; ADDRESS = 8'h05; WRITEDATA = 8'h3C;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    check("rstmid busywait during", BUSYWAIT, 0);
    @(posedge CLK); #1;
    RESET = 1'b0; WRITE = 1'b0;
    @(negedge CLK);
    check("rstmid busywait after", BUSYWAIT, 0);
    check("rstmid readdata", READDATA, 8'h00);
    check("rstmid state", dut.state_q, DM_IDLE);
    exp_rd = 8'h00;
    access("ld05 old", 1'b1, 1'b0, 8'h05, 8'h00, s);

    // back-to-back load then store
    access("stff", 1'b0, 1'b1, 8'hFF, 8'h96, s);
    access("b2b ldff", 1'b1, 1'b0, 8'hFF, 8'h00, s1);
    access("b2b st00", 1'b0, 1'b1, 8'h00, 8'h11, s2);
    check("b2b total stall", s1 + s2, 12);
    check("b2b readdata held", READDATA, 8'h96);
    access("ld00", 1'b1, 1'b0, 8'h00, 8'h00, s);

    // READ and WRITE together act as a store
    access("rdwr40", 1'b1, 1'b1, 8'h40, 8'h77, s);
    access("ld40", 1'b1, 1'b0, 8'h40, 8'h00, s);

    // a second store must not disturb a prior load result
    access("st10b", 1'b0, 1'b1, 8'h10, 8'h3E, s);
    access("ld10b", 1'b1, 1'b0, 8'h10, 8'h00, s);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
